fp_mul: RTL



---
 rtl/fp_mul_pkg.sv | 16 +
 rtl/mul_shiftadd.sv | 46 ++++
 rtl/fp_mul.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared state encoding and default widths for the sequential FP multiplier
package fp_mul_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_EXP_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MUL,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

endpackage

// File: rtl/mul_shiftadd.sv
// rtl/mul_shiftadd.sv - iterative shift-add mantissa multiplier, one multiplier bit per cycle, LSB first
module mul_shiftadd #(
    parameter int DATA_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    output logic [2*DATA_W-1:0]   product,
    output logic                  done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_mcand;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W:0]   w_sum;

    // Partial sum keeps its carry; the {hi, lo} pair shifts right as multiplier bits are consumed.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign done    = (r_cnt == CNT_W'(DATA_W));
    assign product = {r_hi, r_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_cnt   <= CNT_W'(DATA_W);
        end else if (start) begin
            r_hi    <= '0;
            r_lo    <= multiplier;
            r_mcand <= multiplicand;
            r_cnt   <= '0;
        end else if (en && !done) begin
            r_hi    <= w_sum[DATA_W:1];
            r_lo    <= {w_sum[0], r_lo[DATA_W-1:1]};
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul.sv
// rtl/fp_mul.sv - sequential IEEE-754 multiplier: unpack, shift-add multiply, normalise, RNE round
module fp_mul
    import fp_mul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int EXP_W  = DEF_EXP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              overflow,
    output logic              underflow,
    output logic              exception,
    output logic [DATA_W-1:0] res
);

    localparam int MAN_W  = DATA_W - EXP_W;
    localparam int FRAC_W = MAN_W - 1;
    localparam int EW2    = EXP_W + 2;
    localparam logic [EW2-1:0]    BIAS    = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW2-1:0]    EXP_MAX = EW2'((1 << EXP_W) - 1);
    localparam logic [DATA_W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    state_t r_state, w_next;

    logic [DATA_W-1:0]  r_a, r_b, r_res;
    logic               r_sign, r_zero, r_nan;
    logic [EW2-1:0]     r_exp;
    logic [MAN_W-1:0]   r_man;
    logic               r_guard, r_sticky;
    logic               r_ovf, r_unf, r_exc;

    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [2*MAN_W-1:0] w_prod;
    logic               w_mul_done;
    logic               w_inc;
    logic [MAN_W:0]     w_rsum;
    logic [EW2-1:0]     w_fexp;
    logic [FRAC_W-1:0]  w_ffrac;
    logic [DATA_W-1:0]  w_res;
    logic               w_ovf, w_unf, w_exc;

    assign w_ea = r_a[DATA_W-2 -: EXP_W];
    assign w_eb = r_b[DATA_W-2 -: EXP_W];

    mul_shiftadd #(.DATA_W(MAN_W)) u_mul (
        .clk          (clk),
        .rst          (rst),
        .en           (r_state == S_MUL),
        .start        (r_state == S_UNPACK),
        .multiplicand ({1'b1, r_a[FRAC_W-1:0]}),
        .multiplier   ({1'b1, r_b[FRAC_W-1:0]}),
        .product      (w_prod),
        .done         (w_mul_done)
    );

    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = S_UNPACK;
        end else begin
            case (r_state)
                S_UNPACK: w_next = S_MUL;
                S_MUL:    w_next = w_mul_done ? S_NORM : S_MUL;
                S_NORM:   w_next = S_ROUND;
                S_ROUND:  w_next = S_DONE;
                default:  w_next = r_state;
            endcase
        end
    end

    // A carry out of the round increment can only mean the mantissa became exactly 2.0.
    assign w_inc   = r_guard & (r_sticky | r_man[0]);
    assign w_rsum  = {1'b0, r_man} + {{MAN_W{1'b0}}, w_inc};
    assign w_fexp  = r_exp + {{(EW2-1){1'b0}}, w_rsum[MAN_W]};
    assign w_ffrac = w_rsum[MAN_W] ? '0 : w_rsum[FRAC_W-1:0];

    always_comb begin
        w_res = {r_sign, w_fexp[EXP_W-1:0], w_ffrac};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_exc = 1'b0;
        if (r_nan) begin
            w_res = QNAN;
            w_exc = 1'b1;
        end else if (r_zero) begin
            w_res = {r_sign, {(DATA_W-1){1'b0}}};
        end else if ($signed(w_fexp) >= $signed(EXP_MAX)) begin
            w_res = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            w_ovf = 1'b1;
        end else if ($signed(w_fexp) <= 0) begin
            w_res = {r_sign, {(DATA_W-1){1'b0}}};
            w_unf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
            r_nan    <= 1'b0;
            r_exp    <= '0;
            r_man    <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_res    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_exc    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (start) begin
                r_a   <= op_a;
                r_b   <= op_b;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
                r_exc <= 1'b0;
            end else begin
                case (r_state)
                    S_UNPACK: begin
                        r_sign <= r_a[DATA_W-1] ^ r_b[DATA_W-1];
                        r_nan  <= (&w_ea) | (&w_eb);
                        r_zero <= (w_ea == '0) | (w_eb == '0);
                        r_exp  <= {2'b00, w_ea} + {2'b00, w_eb} - BIAS;
                    end
                    S_NORM: begin
                        if (w_prod[2*MAN_W-1]) begin
                            r_man    <= w_prod[2*MAN_W-1:MAN_W];
                            r_guard  <= w_prod[MAN_W-1];
                            r_sticky <= |w_prod[MAN_W-2:0];
                            r_exp    <= r_exp + 1'b1;
                        end else begin
                            r_man    <= w_prod[2*MAN_W-2:MAN_W-1];
                            r_guard  <= w_prod[MAN_W-2];
                            r_sticky <= |w_prod[MAN_W-3:0];
                        end
                    end
                    S_ROUND: begin
                        r_res <= w_res;
                        r_ovf <= w_ovf;
                        r_unf <= w_unf;
                        r_exc <= w_exc;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign done      = (r_state == S_IDLE) || (r_state == S_DONE);
    assign res       = r_res;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign exception = r_exc;

endmodule
